timestamp_capture_unit: RTL

Parametrised free-running timestamp counter. Adds a programmable per-cycle increment, an absolute load, a signed offset adjust and wrap signalling. Provides NUM_CHANNELS independent capture channels that snapshot the counter on request and hold the value until a consumer acknowledges it. The block sits in the data path and timestamps packet events (SOF/EOF) for the tx and rx engines.

---
 rtl/timestamp_capture_unit.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/timestamp_capture_unit.sv
// Free-running timestamp counter with load/adjust/wrap, plus NUM_CHANNELS
// independent single-entry capture registers that hold a snapshot until acked.
module timestamp_capture_unit #(
    parameter int TIME_STAMP_DWIDTH = 64,
    parameter int NUM_CHANNELS      = 4,
    parameter int INC_WIDTH         = 8,
    parameter int ADJ_WIDTH         = 32
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      enable,
    input  logic [INC_WIDTH-1:0]                      inc_val,
    input  logic                                      load_valid,
    input  logic [TIME_STAMP_DWIDTH-1:0]              load_val,
    input  logic                                      adj_valid,
    input  logic [ADJ_WIDTH-1:0]                      adj_val,
    input  logic [NUM_CHANNELS-1:0]                   cap_req,
    input  logic [NUM_CHANNELS-1:0]                   cap_ack,
    output logic [TIME_STAMP_DWIDTH-1:0]              counter_val,
    output logic                                      wrap_pulse,
    output logic [NUM_CHANNELS-1:0]                   cap_valid,
    output logic [NUM_CHANNELS*TIME_STAMP_DWIDTH-1:0] cap_data,
    output logic [NUM_CHANNELS-1:0]                   cap_overrun
);

    localparam int W = TIME_STAMP_DWIDTH;

    // ------------------------------------------------------------------
    // Counter datapath
    // ------------------------------------------------------------------
    logic [W-1:0]                 counter_q;
    logic [W-1:0]                 counter_d;
    logic                         wrap_q;
    logic                         wrap_d;
    logic [W-1:0]                 inc_ext;
    logic [W-1:0]                 inc_term;
    logic signed [ADJ_WIDTH-1:0]  adj_signed;
    logic [W-1:0]                 adj_ext;
    logic [W:0]                   inc_sum;
    logic [W-1:0]                 adj_sum;

    assign inc_ext    = W'(inc_val);
    assign inc_term   = enable ? inc_ext : '0;
    assign adj_signed = adj_val;
    // Signed size cast sign-extends the offset to the counter width.
    assign adj_ext    = W'(adj_signed);
    assign inc_sum    = {1'b0, counter_q} + {1'b0, inc_ext};
    assign adj_sum    = counter_q + inc_term + adj_ext;

    always_comb begin
        counter_d = counter_q;
        wrap_d    = 1'b0;
        if (load_valid) begin
            counter_d = load_val;
        end else if (adj_valid) begin
            counter_d = adj_sum;
        end else if (enable) begin
            counter_d = inc_sum[W-1:0];
            wrap_d    = inc_sum[W];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            counter_q <= '0;
            wrap_q    <= 1'b0;
        end else begin
            counter_q <= counter_d;
            wrap_q    <= wrap_d;
        end
    end

    assign counter_val = counter_q;
    assign wrap_pulse  = wrap_q;

    // ------------------------------------------------------------------
    // Capture channels
    // Handshake: cap_valid high means cap_data holds an unconsumed snapshot;
    // a cap_ack while cap_valid is high consumes it (and may be paired with a
    // cap_req in the same cycle to relatch); cap_ack while empty is ignored.
    // The per-channel state is visible directly as cap_valid.
    // ------------------------------------------------------------------
    typedef enum logic {
        CH_EMPTY = 1'b0,
        CH_FULL  = 1'b1
    } ch_state_t;

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_chan
        ch_state_t    state_q;
        ch_state_t    state_d;
        logic [W-1:0] data_q;
        logic [W-1:0] data_d;
        logic         ovr_q;
        logic         ovr_d;

        always_comb begin
            state_d = state_q;
            data_d  = data_q;
            ovr_d   = ovr_q;
            case (state_q)
                CH_EMPTY: begin
                    if (cap_req[g]) begin
                        state_d = CH_FULL;
                        data_d  = counter_q;
                    end
                end
                CH_FULL: begin
                    if (cap_ack[g]) begin
                        ovr_d = 1'b0;
                        if (cap_req[g]) begin
                            data_d = counter_q;
                        end else begin
                            state_d = CH_EMPTY;
                        end
                    end else if (cap_req[g]) begin
                        ovr_d = 1'b1;
                    end
                end
                default: begin
                    state_d = CH_EMPTY;
                end
            endcase
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                state_q <= CH_EMPTY;
                data_q  <= '0;
                ovr_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                data_q  <= data_d;
                ovr_q   <= ovr_d;
            end
        end

        assign cap_valid[g]           = (state_q == CH_FULL);
        assign cap_data[g*W +: W]     = data_q;
        assign cap_overrun[g]         = ovr_q;
    end

endmodule
